// File: rtl/i2c_result_target.sv
// I2C target exposing the configuration byte and four BCD lag measurements
// (current, minimum, maximum, average) to an external host, plus one
// host-writable scratch register.
//
// Ports:
//   clock        system clock (same domain as the measurement logic)
//   reset        asynchronous active-low reset
//   scl_in       raw SCL pad level
//   sda_in       raw SDA pad level
//   sda_oe       1 pulls SDA low (pad is sda_oe ? 0 : z)
//   config_data  current configuration byte
//   bcd_*        20-bit BCD measurements
//   scratch      host-writable register (pointer 0x0E)
//   busy         high from an accepted START until STOP
module i2c_result_target #(
    parameter logic [6:0]  ADDRESS    = 7'h3A,
    parameter logic [7:0]  DEVICE_ID  = 8'hA5,
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [7:0]  config_data,
    input  logic [19:0] bcd_current,
    input  logic [19:0] bcd_minimum,
    input  logic [19:0] bcd_maximum,
    input  logic [19:0] bcd_average,
    output logic [7:0]  scratch,
    output logic        busy
);

    localparam logic [3:0] FiltMax = 4'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        StIdle, StAddr, StAddrAck, StWrByte, StWrAck, StRdByte, StRdAck, StIgnore
    } state_e;

    // Input conditioning, index 0 = SCL, index 1 = SDA.
    logic [1:0] sync1_q, sync2_q, filt_q, filt_d, prev_q;
    logic [3:0] cnt_q [2];
    logic [3:0] cnt_d [2];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            filt_d[i] = filt_q[i];
            cnt_d[i]  = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (cnt_q[i] == FiltMax) filt_d[i] = sync2_q[i];
                else                     cnt_d[i]  = cnt_q[i] + 4'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            filt_q   <= '1;
            prev_q   <= '1;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            sync1_q <= {sda_in, scl_in};
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            prev_q  <= filt_q;
            cnt_q   <= cnt_d;
        end
    end

    logic scl_rise, scl_fall, sda_lvl, start_det, stop_det;
    assign scl_rise  = filt_q[0] & ~prev_q[0];
    assign scl_fall  = ~filt_q[0] & prev_q[0];
    assign sda_lvl   = filt_q[1];
    // SDA edges are qualified with the SCL level of the previous cycle.
    assign start_det = ~filt_q[1] & prev_q[1] & prev_q[0];
    assign stop_det  = filt_q[1] & ~prev_q[1] & prev_q[0];

    state_e      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d, pointer_q, pointer_d, scratch_q, scratch_d;
    logic        rw_q, rw_d, first_q, first_d, sda_oe_q, sda_oe_d, busy_q, busy_d;
    logic        snap_en;
    logic [7:0]  cfg_sh_q;
    logic [19:0] cur_sh_q, min_sh_q, max_sh_q, avg_sh_q;
    logic [7:0]  rd_byte;
    logic [2:0]  bit_idx;

    always_comb begin
        unique case (pointer_q)
            8'h00:   rd_byte = DEVICE_ID;
            8'h01:   rd_byte = cfg_sh_q;
            8'h02:   rd_byte = {4'h0, cur_sh_q[19:16]};
            8'h03:   rd_byte = cur_sh_q[15:8];
            8'h04:   rd_byte = cur_sh_q[7:0];
            8'h05:   rd_byte = {4'h0, min_sh_q[19:16]};
            8'h06:   rd_byte = min_sh_q[15:8];
            8'h07:   rd_byte = min_sh_q[7:0];
            8'h08:   rd_byte = {4'h0, max_sh_q[19:16]};
            8'h09:   rd_byte = max_sh_q[15:8];
            8'h0A:   rd_byte = max_sh_q[7:0];
            8'h0B:   rd_byte = {4'h0, avg_sh_q[19:16]};
            8'h0C:   rd_byte = avg_sh_q[15:8];
            8'h0D:   rd_byte = avg_sh_q[7:0];
            8'h0E:   rd_byte = scratch_q;
            default: rd_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        pointer_d = pointer_q;
        scratch_d = scratch_q;
        rw_d      = rw_q;
        first_d   = first_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        snap_en   = 1'b0;
        bit_idx   = 3'(4'd7 - bit_cnt_q);

        if (start_det) begin
            state_d   = StAddr;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
        end else if (stop_det) begin
            state_d  = StIdle;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StAddr, StWrByte: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_lvl};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        if (state_q == StAddr) begin
                            if (shift_q[7:1] == ADDRESS) begin
                                state_d  = StAddrAck;
                                sda_oe_d = 1'b1;
                                rw_d     = shift_q[0];
                                snap_en  = shift_q[0];
                            end else begin
                                state_d = StIgnore;
                            end
                        end else begin
                            state_d  = StWrAck;
                            sda_oe_d = 1'b1;
                            if (first_q) begin
                                pointer_d = shift_q;
                                first_d   = 1'b0;
                            end else begin
                                if (pointer_q == 8'h0E) scratch_d = shift_q;
                                pointer_d = pointer_q + 8'd1;
                            end
                        end
                    end
                end
                StAddrAck: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (rw_q) begin
                            state_d  = StRdByte;
                            sda_oe_d = ~rd_byte[7];
                        end else begin
                            state_d  = StWrByte;
                            sda_oe_d = 1'b0;
                            first_d  = 1'b1;
                        end
                    end
                end
                StWrAck: begin
                    if (scl_fall) begin
                        state_d  = StWrByte;
                        sda_oe_d = 1'b0;
                    end
                end
                StRdByte: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            state_d   = StRdAck;
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            pointer_d = pointer_q + 8'd1;
                        end else begin
                            sda_oe_d = ~rd_byte[bit_idx];
                        end
                    end
                end
                StRdAck: begin
                    // bit_cnt 9 marks a host ACK seen on this clock's rise.
                    if (scl_rise) begin
                        if (sda_lvl) state_d   = StIgnore;
                        else         bit_cnt_d = 4'd9;
                    end else if (scl_fall && bit_cnt_q == 4'd9) begin
                        state_d   = StRdByte;
                        bit_cnt_d = '0;
                        sda_oe_d  = ~rd_byte[7];
                    end
                end
                StIgnore: sda_oe_d = 1'b0;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            pointer_q <= '0;
            scratch_q <= '0;
            rw_q      <= 1'b0;
            first_q   <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            pointer_q <= pointer_d;
            scratch_q <= scratch_d;
            rw_q      <= rw_d;
            first_q   <= first_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
        end
    end

    // Shadow copies keep a multi-byte read coherent.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cfg_sh_q <= '0;
            cur_sh_q <= '0;
            min_sh_q <= '0;
            max_sh_q <= '0;
            avg_sh_q <= '0;
        end else if (snap_en) begin
            cfg_sh_q <= config_data;
            cur_sh_q <= bcd_current;
            min_sh_q <= bcd_minimum;
            max_sh_q <= bcd_maximum;
            avg_sh_q <= bcd_average;
        end
    end

    assign sda_oe  = sda_oe_q;
    assign scratch = scratch_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_i2c_result_target.sv
module tb_i2c_result_target;

    localparam int Q = 10;  // quarter SCL period in clock cycles

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        scl = 1'b1;
    logic        host_sda = 1'b1;
    logic        sda_line;
    logic        sda_oe;
    logic [7:0]  config_data = 8'h00;
    logic [19:0] bcd_current = '0, bcd_minimum = '0, bcd_maximum = '0, bcd_average = '0;
    logic [7:0]  scratch;
    logic        busy;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] model_ptr = 8'h00;
    logic [7:0] model_scratch = 8'h00;
    logic [7:0]  s_cfg;
    logic [19:0] s_cur, s_min, s_max, s_avg;

    bit oe_watch = 1'b0;
    int oe_cnt = 0;

    assign sda_line = host_sda & ~sda_oe;

    i2c_result_target dut (
        .clock       (clock),
        .reset       (reset),
        .scl_in      (scl),
        .sda_in      (sda_line),
        .sda_oe      (sda_oe),
        .config_data (config_data),
        .bcd_current (bcd_current),
        .bcd_minimum (bcd_minimum),
        .bcd_maximum (bcd_maximum),
        .bcd_average (bcd_average),
        .scratch     (scratch),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (oe_watch && sda_oe) oe_cnt <= oe_cnt + 1;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Register image built straight from the published register map.
    function automatic logic [7:0] model_reg(input logic [7:0] p);
        logic [7:0]  img [256];
        logic [19:0] m [4];
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
        m = '{s_cur, s_min, s_max, s_avg};
        img[0] = 8'hA5;
        img[1] = s_cfg;
        for (int k = 0; k < 4; k++) begin
            img[2 + 3 * k] = {4'h0, m[k][19:16]};
            img[3 + 3 * k] = m[k][15:8];
            img[4 + 3 * k] = m[k][7:0];
        end
        img[14] = model_scratch;
        return img[p];
    endfunction

    function automatic logic [19:0] rand_bcd();
        logic [19:0] v;
        for (int i = 0; i < 5; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    task automatic rand_inputs();
        config_data = 8'($urandom);
        bcd_current = rand_bcd();
        bcd_minimum = rand_bcd();
        bcd_maximum = rand_bcd();
        bcd_average = rand_bcd();
    endtask

    task automatic take_snapshot();
        s_cfg = config_data;
        s_cur = bcd_current;
        s_min = bcd_minimum;
        s_max = bcd_maximum;
        s_avg = bcd_average;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic bus_bit(input logic b, output logic r);
        host_sda = b;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        r = sda_line;
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic bus_start();
        host_sda = 1'b1;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        host_sda = 1'b0;
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic bus_stop();
        host_sda = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        host_sda = 1'b1;
        wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
        bus_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, r);
            d[i] = r;
        end
        bus_bit(~ack, r);
    endtask

    // START, address-write, pointer byte; leaves the bus held for a repeated START.
    task automatic set_pointer(input logic [7:0] p, output logic ok);
        logic a1, a2;
        bus_start();
        write_byte(8'h74, a1);
        write_byte(p, a2);
        ok = a1 & a2;
        model_ptr = p;
    endtask

    task automatic chk_bit(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic chk_byte(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        logic ack;
        logic [7:0] d;
        rand_inputs();
        reset = 1'b0;
        wait_clk(5);
        chk_bit("reset sda_oe", sda_oe, 1'b0);
        chk_byte("reset scratch", scratch, 8'h00);
        chk_bit("reset busy", busy, 1'b0);
        reset = 1'b1;
        wait_clk(Q);
        // Pointer starts at 0 after reset.
        bus_start();
        write_byte(8'h75, ack);
        chk_bit("reset read addr ack", ack, 1'b1);
        take_snapshot();
        read_byte(1'b0, d);
        chk_byte("reset pointer read", d, model_reg(model_ptr));
        model_ptr++;
        bus_stop();
    endtask

    task automatic test_addr_match();
        logic ack;
        int base;
        bus_start();
        write_byte(8'h74, ack);
        chk_bit("match ack", ack, 1'b1);
        chk_bit("match busy", busy, 1'b1);
        bus_stop();
        chk_bit("stop busy", busy, 1'b0);
        oe_watch = 1'b1;
        wait_clk(1);
        base = oe_cnt;
        bus_start();
        write_byte(8'h76, ack);
        chk_bit("mismatch ack", ack, 1'b0);
        write_byte(8'($urandom), ack);
        chk_bit("mismatch data ack", ack, 1'b0);
        bus_stop();
        n_checks++;
        if (oe_cnt != base) begin
            n_fail++;
            $display("FAIL mismatch sda_oe: got %0d driven cycles expected 0", oe_cnt - base);
        end
        oe_watch = 1'b0;
    endtask

    task automatic test_id_read();
        logic ok, ack;
        logic [7:0] d;
        rand_inputs();
        set_pointer(8'h00, ok);
        chk_bit("id pointer ack", ok, 1'b1);
        bus_start();
        write_byte(8'h75, ack);
        chk_bit("id read ack", ack, 1'b1);
        take_snapshot();
        read_byte(1'b1, d);
        chk_byte("id reg0", d, model_reg(model_ptr));
        model_ptr++;
        read_byte(1'b0, d);
        chk_byte("id reg1", d, model_reg(model_ptr));
        model_ptr++;
        bus_stop();
        chk_bit("id busy after stop", busy, 1'b0);
    endtask

    task automatic test_coherent_burst();
        logic ok, ack;
        logic [7:0] d, p;
        int n;
        for (int it = 0; it < 6; it++) begin
            rand_inputs();
            p = (it == 0) ? 8'h02 : 8'($urandom_range(0, 16));
            n = (it == 0) ? 3 : $urandom_range(1, 4);
            if (it == 0) bcd_current = 20'h12345;
            if (it % 2 == 0) begin
                set_pointer(p, ok);
                chk_bit("burst pointer ack", ok, 1'b1);
            end
            bus_start();
            write_byte(8'h75, ack);
            chk_bit("burst read ack", ack, 1'b1);
            take_snapshot();
            for (int j = 0; j < n; j++) begin
                read_byte(j != n - 1, d);
                chk_byte($sformatf("burst it%0d ptr%02h", it, model_ptr), d, model_reg(model_ptr));
                model_ptr++;
                if (j == 0) begin
                    rand_inputs();
                    if (it == 0) bcd_current = 20'h99999;
                end
            end
            bus_stop();
        end
    endtask

    task automatic test_scratch_write();
        logic ok, ack;
        logic [7:0] v, d;
        v = 8'($urandom);
        set_pointer(8'h0E, ok);
        write_byte(v, ack);
        chk_bit("scratch data ack", ok & ack, 1'b1);
        model_scratch = v;
        model_ptr = 8'h0F;
        bus_stop();
        chk_byte("scratch value", scratch, v);
        set_pointer(8'h01, ok);
        write_byte(8'h77, ack);
        chk_bit("ro write ack", ok & ack, 1'b1);
        model_ptr = 8'h02;
        bus_stop();
        chk_byte("scratch kept", scratch, v);
        rand_inputs();
        set_pointer(8'h01, ok);
        bus_start();
        write_byte(8'h75, ack);
        take_snapshot();
        read_byte(1'b0, d);
        chk_byte("ro reg1", d, model_reg(model_ptr));
        model_ptr++;
        bus_stop();
        set_pointer(8'h0D, ok);
        bus_start();
        write_byte(8'h75, ack);
        take_snapshot();
        for (int j = 0; j < 3; j++) begin
            read_byte(j != 2, d);
            chk_byte($sformatf("scratch area ptr%02h", model_ptr), d, model_reg(model_ptr));
            model_ptr++;
        end
        bus_stop();
    endtask

    task automatic test_wrap();
        logic ok, ack;
        logic [7:0] d;
        set_pointer(8'hFF, ok);
        bus_start();
        write_byte(8'h75, ack);
        chk_bit("wrap ack", ok & ack, 1'b1);
        take_snapshot();
        for (int j = 0; j < 2; j++) begin
            read_byte(j == 0, d);
            chk_byte($sformatf("wrap byte%0d", j), d, model_reg(model_ptr));
            model_ptr++;
        end
        bus_stop();
    endtask

    task automatic test_glitch();
        logic ok, r;
        logic [7:0] v;
        // Short low pulse on idle bus looks like a START if unfiltered.
        host_sda = 1'b0;
        wait_clk(2);
        host_sda = 1'b1;
        wait_clk(Q);
        chk_bit("glitch idle busy", busy, 1'b0);
        v = {1'b0, 7'($urandom)};
        set_pointer(8'h0E, ok);
        chk_bit("glitch pointer ack", ok, 1'b1);
        // Data bit 7 = 0 with a short high pulse while SCL is high (fake STOP).
        host_sda = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        host_sda = 1'b1;
        wait_clk(2);
        host_sda = 1'b0;
        wait_clk(Q);
        chk_bit("glitch busy held", busy, 1'b1);
        scl = 1'b0;
        wait_clk(Q);
        for (int i = 6; i >= 0; i--) bus_bit(v[i], r);
        bus_bit(1'b1, r);
        chk_bit("glitch data ack", r, 1'b0);
        model_scratch = v;
        model_ptr = 8'h0F;
        bus_stop();
        chk_byte("glitch scratch", scratch, v);
    endtask

    task automatic test_reset_mid();
        logic r, ok, ack;
        logic [7:0] addr, v;
        addr = 8'h74;
        bus_start();
        for (int i = 7; i >= 0; i--) bus_bit(addr[i], r);
        chk_bit("ack driven before reset", sda_oe, 1'b1);
        reset = 1'b0;
        #1;
        chk_bit("reset drops sda_oe", sda_oe, 1'b0);
        chk_bit("reset drops busy", busy, 1'b0);
        scl = 1'b1;
        host_sda = 1'b1;
        wait_clk(5);
        reset = 1'b1;
        model_scratch = 8'h00;
        model_ptr = 8'h00;
        wait_clk(Q);
        chk_byte("post reset scratch", scratch, 8'h00);
        v = 8'($urandom);
        set_pointer(8'h0E, ok);
        write_byte(v, ack);
        chk_bit("post reset write ack", ok & ack, 1'b1);
        model_scratch = v;
        bus_stop();
        chk_byte("post reset scratch write", scratch, v);
    endtask

    initial begin
        test_reset();
        test_addr_match();
        test_id_read();
        test_coherent_burst();
        test_scratch_write();
        test_wrap();
        test_glitch();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_result_target.md
# i2c_result_target

I2C target (responder) that exposes the current configuration byte and the four BCD lag measurements (current, minimum, maximum, average) to an external host over a two-wire bus. It is the bus-responder counterpart of the TFP410 configuration initiator. It sits in the `clock` domain next to `measure` and `configuration`, and drives the shared SDA pad open-drain.

## Interface
- `ADDRESS`, default 7'h3A: 7-bit target address.
- `DEVICE_ID`, default 8'hA5: value returned at register 0x00.
- `FILTER_LEN`, default 4: `clock` cycles an input must stay stable before the filtered level changes (range 1–15).
- `clock` input, 1 bit: system clock, the same domain as `measure`.
- `reset` input, 1 bit: asynchronous, active-low.
- `scl_in` input, 1 bit: raw SCL pad level.
- `sda_in` input, 1 bit: raw SDA pad level.
- `sda_oe` output, 1 bit: 1 drives SDA low. The top level ties the pad as `sda_oe ? 0 : z`.
- `config_data` input, 8 bits: current configuration byte.
- `bcd_current`, `bcd_minimum`, `bcd_maximum`, `bcd_average` inputs, 20 bits each: BCD measurements.
- `scratch` output, 8 bits: host-writable register.
- `busy` output, 1 bit: high from an accepted START until STOP.

## Operation
- **Input conditioning:** a 2-flop synchronizer feeds a stability counter for each line. A filtered level updates only after `FILTER_LEN` consecutive equal samples. Edges are detected on the filtered levels.
- **START:** filtered SDA falls while filtered SCL is high. Accepted in any state, including repeated START; go to ADDR with the bit counter at 0.
- **STOP:** filtered SDA rises while filtered SCL is high. From any state go to IDLE, release SDA, clear `busy`.
- **States:** IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
  - **ADDR:** shift 8 bits (address, then R/W), MSB first, sampled on SCL rise.
    - Match → ADDR_ACK.
    - Mismatch → IGNORE, which holds SDA released until START/STOP.
  - **ADDR_ACK:** drive SDA low for the 9th clock.
    - On write: next state WR_BYTE.
    - On read: load the snapshot (below), then RD_BYTE.
  - **WR_BYTE:** first byte after an address-write loads `pointer`. Each later byte writes the register at `pointer`, then `pointer` increments. Every byte is ACKed in WR_ACK.
  - **RD_BYTE:** present the byte at `pointer`, MSB first. Each bit changes on the SCL falling edge. `pointer` increments after the 8th bit.
  - **RD_ACK:** release SDA and sample the host bit on SCL rise.
    - ACK (0) → RD_BYTE.
    - NACK (1) → IGNORE until STOP/START.
- **Register map (8-bit pointer):**
  - 0x00: `DEVICE_ID`.
  - 0x01: config snapshot.
  - 0x02–0x04: current, as {4'h0, bcd[19:16]}, bcd[15:8], bcd[7:0].
  - 0x05–0x07: minimum, same layout.
  - 0x08–0x0A: maximum, same layout.
  - 0x0B–0x0D: average, same layout.
  - 0x0E: `scratch`, read/write.
  - 0x0F–0xFF: read 0x00.
- **Write rules:** only 0x0E is writable. Writes elsewhere are ACKed and discarded.
- **Pointer:** wraps 0xFF→0x00. It keeps its value across transactions, so a write with only a pointer byte followed by a repeated-START read reads from that pointer.
- **Snapshot:** all 88 input bits are captured into shadow registers in the cycle the read address is ACKed. Reads within one transaction are therefore coherent. Inputs changing mid-read do not affect the data returned.

## Timing
- **Reset values:**
  - `sda_oe`=0, `scratch`=8'h00, `busy`=0.
  - State IDLE, `pointer`=0, shadows 0.
  - Filtered SCL/SDA = 1.
- **Latency:** raw pin change to filtered edge is 2 + `FILTER_LEN` cycles.
- **Drive timing:** `sda_oe` updates one cycle after a filtered SCL fall.
  - ACK drive asserts on the fall after the 8th bit.
  - ACK drive releases on the fall after the 9th bit.
- **No clock stretching:** the minimum SCL low period must exceed `FILTER_LEN`+4 `clock` cycles.
- **Simultaneous events:** if SCL and SDA filtered edges occur in the same cycle, the SDA edge is evaluated against the previous SCL level.
- **Reset mid-transaction:** `sda_oe` drops to 0 asynchronously. Any partial write is discarded.

## Test plan
- **Address match:** START, write to 0x3A (byte 0x74) → ACK on 9th clock, `busy`=1. Write to 0x3B → no ACK, `sda_oe` stays 0 until STOP.
- **Pointer + ID read:** write pointer 0x00, repeated START, read (0x75), 2 bytes with ACK then NACK → 0xA5, 0x40 when `config_data`=0x40. STOP → `busy`=0.
- **Coherent burst read:** `bcd_current`=20'h12345, pointer 0x02, read 3 bytes → 0x01, 0x23, 0x45. Changing `bcd_current` to 20'h99999 mid-read does not alter the returned bytes.
- **Scratch write:** write pointer 0x0E, data 0x5C → `scratch`=0x5C. Then write 0x77 at pointer 0x01 → ACKed, read of 0x01 is still `config_data`.
- **Wrap-around:** pointer 0xFF, read 2 bytes → 0x00, 0xA5.
- **Glitch and reset:** a 2-cycle SDA pulse while SCL is high → no START/STOP detected. Assert `reset` while ACK is driven → `sda_oe`=0 the same cycle, next transaction is decoded normally.
